// File: rtl/mil1553_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mil1553_pkg
//  Description : Shared types and constants for the MIL-STD-1553 Manchester II
//                transmit encoder: state enumeration, sync patterns (TX+
//                half-bit levels, first half-bit in the MSB), word geometry
//                and the odd-parity helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package mil1553_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_e;

  localparam logic [5:0] SYNC_CMD        = 6'b111000;
  localparam logic [5:0] SYNC_DATA       = 6'b000111;
  localparam int         WORD_HALFBITS   = 40;
  localparam int         SYNC_HALFBITS   = 6;
  localparam int         DATA_HALFBITS   = 32;
  localparam int         PARITY_HALFBITS = 2;

  // Odd parity over data plus parity bit: parity bit set when data has an
  // even number of ones.
  function automatic logic odd_parity(input logic [15:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mil1553_halfbit_tick.sv
`default_nettype none
// ============================================================================
//  Module      : mil1553_halfbit_tick
//  Description : Half-bit timebase. Counts aclk cycles while enabled and
//                emits a one-clock strobe on the last clock of every half-bit
//                (every CLOCK_SPEED/2000000 clocks). Restart forces the count
//                back to zero so a new word starts on a clean half-bit.
//  Parameters  : CLOCK_SPEED - aclk frequency in Hz (multiple of 2 MHz)
//  Ports       : aclk_i     in  1  clock
//                reset_i    in  1  synchronous active-high reset
//                en_i       in  1  count enable (held at zero when low)
//                restart_i  in  1  restart the half-bit from clock 0
//                tick_o     out 1  last clock of the current half-bit
//  Revision    : 1.0  initial release
// ============================================================================
module mil1553_halfbit_tick #(
  parameter int CLOCK_SPEED = 12000000
) (
  input  logic aclk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int HB    = CLOCK_SPEED / 2000000;
  localparam int CNT_W = (HB > 1) ? $clog2(HB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HB - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mil1553_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : mil1553_tx_encoder
//  Description : MIL-STD-1553 Manchester II transmit encoder. Accepts 16-bit
//                words on an AXI-stream slave and sends 3-bit-time sync, 16
//                data bits MSB first and an odd parity bit at 1 Mbit/s on the
//                transceiver TX+/TX- pair. Back-to-back words are sent with
//                no gap when the next word is offered on the last clock of
//                the parity bit; otherwise a bus-quiet gap follows.
//  Parameters  : CLOCK_SPEED  - aclk frequency in Hz (multiple of 2 MHz, >= 4 MHz)
//                GAP_HALFBITS - quiet half-bits after a non-contiguous word
//  Config      : MIL1553_TX_PARITY_INJECT_EN - when defined, s_axis_tuser[1]
//                inverts the transmitted parity bit (parity error injection)
//  Ports       : aclk           in  1   clock
//                reset          in  1   synchronous active-high reset
//                s_axis_tdata   in  16  word payload, bit 15 first
//                s_axis_tuser   in  8   [0] command/status sync, [1] parity inject
//                s_axis_tvalid  in  1   word available
//                s_axis_tready  out 1   word accepted this clock
//                tx_diff        out 2   {TX+, TX-}, 2'b00 when idle
//                tx_en          out 1   transceiver drive enable
//  Revision    : 1.0  initial release
// ============================================================================
module mil1553_tx_encoder
  import mil1553_pkg::*;
#(
  parameter int CLOCK_SPEED  = 12000000,
  parameter int GAP_HALFBITS = 8
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [15:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  tx_diff,
  output logic        tx_en
);

  localparam int IDX_MAX = (GAP_HALFBITS > DATA_HALFBITS) ? GAP_HALFBITS : DATA_HALFBITS;
  localparam int IDX_W   = $clog2(IDX_MAX);

  localparam logic [IDX_W-1:0] SYNC_LAST   = IDX_W'(SYNC_HALFBITS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST   = IDX_W'(DATA_HALFBITS - 1);
  localparam logic [IDX_W-1:0] PARITY_LAST = IDX_W'(PARITY_HALFBITS - 1);
  localparam logic [IDX_W-1:0] GAP_LAST    = IDX_W'(GAP_HALFBITS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       word_q, word_d;
  logic              cmd_q, cmd_d;
  logic              par_q, par_d;
  logic              rdy_en_q;
  logic [1:0]        tx_diff_q, tx_diff_d;
  logic              tx_en_q, tx_en_d;

  logic              tick;
  logic              hs;
  logic              load;
  logic              par_new;
  logic              lvl;
  logic              active;
  logic [5:0]        sync_sh;
  logic [15:0]       data_sh;
  logic              unused_tuser_w;

`ifdef MIL1553_TX_PARITY_INJECT_EN
  assign par_new        = odd_parity(s_axis_tdata) ^ s_axis_tuser[1];
  assign unused_tuser_w = ^s_axis_tuser[7:2];
`else
  assign par_new        = odd_parity(s_axis_tdata);
  assign unused_tuser_w = ^s_axis_tuser[7:1];
`endif

  mil1553_halfbit_tick #(
    .CLOCK_SPEED (CLOCK_SPEED)
  ) u_tick (
    .aclk_i    (aclk),
    .reset_i   (reset),
    .en_i      (state_q != IDLE),
    .restart_i (hs),
    .tick_o    (tick)
  );

  // Ready is open while idle and for the single last clock of the parity
  // bit; rdy_en_q keeps it low for the first clock after reset.
  assign s_axis_tready = rdy_en_q &&
                         ((state_q == IDLE) ||
                          ((state_q == PARITY) && (idx_q == PARITY_LAST) && tick));
  assign hs = s_axis_tvalid && s_axis_tready;

  // Next state and half-bit index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SYNC;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      SYNC: begin
        if (tick) begin
          if (idx_q == SYNC_LAST) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == DATA_LAST) begin
            state_d = PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          idx_d = '0;
          if (idx_q == PARITY_LAST) begin
            if (hs) begin
              state_d = SYNC;
              load    = 1'b1;
            end else if (GAP_HALFBITS > 0) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (idx_q == GAP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Word capture
  always_comb begin
    word_d = word_q;
    cmd_d  = cmd_q;
    par_d  = par_q;
    if (load) begin
      word_d = s_axis_tdata;
      cmd_d  = s_axis_tuser[0];
      par_d  = par_new;
    end
  end

  // Line level for the half-bit that will be on the bus next clock. Computed
  // from next-state values so the registered outputs line up with the state.
  // Manchester: second half of each bit is the complement of the first.
  always_comb begin
    sync_sh   = (cmd_d ? SYNC_CMD : SYNC_DATA) << idx_d[2:0];
    data_sh   = word_d << idx_d[4:1];
    lvl       = 1'b0;
    active    = 1'b0;
    case (state_d)
      SYNC: begin
        active = 1'b1;
        lvl    = sync_sh[5];
      end
      DATA: begin
        active = 1'b1;
        lvl    = data_sh[15] ^ idx_d[0];
      end
      PARITY: begin
        active = 1'b1;
        lvl    = par_d ^ idx_d[0];
      end
      default: begin
        active = 1'b0;
        lvl    = 1'b0;
      end
    endcase
    tx_en_d   = active;
    tx_diff_d = active ? {lvl, ~lvl} : 2'b00;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      cmd_q     <= 1'b0;
      par_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
      tx_diff_q <= 2'b00;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      cmd_q     <= cmd_d;
      par_q     <= par_d;
      rdy_en_q  <= 1'b1;
      tx_diff_q <= tx_diff_d;
      tx_en_q   <= tx_en_d;
    end
  end

  assign tx_diff = tx_diff_q;
  assign tx_en   = tx_en_q;

endmodule
`default_nettype wire

// File: tb/tb_mil1553_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mil1553_tx_encoder
//  Description : Self-checking bench for mil1553_tx_encoder. Words (directed
//                and $urandom) are offered with random idle delays; a word-
//                level reference model builds the 40 half-bit TX+ levels of
//                each accepted word and predicts tready/tx_en/tx_diff for
//                every clock. Includes a reset abort in mid-word.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mil1553_tx_encoder;

  localparam int CLOCK_SPEED  = 12000000;
  localparam int GAP_HALFBITS = 8;
  localparam int HB           = CLOCK_SPEED / 2000000;
  localparam int WORD_CLKS    = 40 * HB;
  localparam int GAP_CLKS     = GAP_HALFBITS * HB;
  localparam int BUDGET       = 60000;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tuser = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [1:0]  tx_diff;
  logic        tx_en;

  always #5 aclk = ~aclk;

  mil1553_tx_encoder #(
    .CLOCK_SPEED  (CLOCK_SPEED),
    .GAP_HALFBITS (GAP_HALFBITS)
  ) dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .tx_diff       (tx_diff),
    .tx_en         (tx_en)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [7:0]  user;
    int          delay;
    int          abort_at;
  } item_t;

  item_t stim[$];

  // Reference model: mode 0 idle, 1 word on the bus, 2 quiet gap
  int  m_mode;
  int  m_pos;
  bit  m_settle;
  int  m_abort;
  bit  m_lv[40];

  task automatic build_levels(input logic [15:0] d, input logic [7:0] u);
    bit [5:0] sync;
    bit       par;
    sync = u[0] ? 6'b111000 : 6'b000111;
    for (int i = 0; i < 6; i++) m_lv[i] = sync[5-i];
    for (int k = 0; k < 16; k++) begin
      m_lv[6 + 2*k]     = d[15-k];
      m_lv[6 + 2*k + 1] = ~d[15-k];
    end
    par = (($countones(d) % 2) == 0);
`ifdef MIL1553_TX_PARITY_INJECT_EN
    if (u[1]) par = ~par;
`endif
    m_lv[38] = par;
    m_lv[39] = ~par;
  endtask

  function automatic item_t mk(input logic [15:0] d, input logic [7:0] u, input int dl, input int ab);
    item_t it;
    it.data = d; it.user = u; it.delay = dl; it.abort_at = ab;
    return it;
  endfunction

  initial begin
    item_t cur;
    bit    have;
    int    dly;
    int    rst_hold;
    int    cycles;
    bit    exp_rdy;
    bit    exp_en;
    logic [1:0] exp_diff;
    bit    hs;
    bit    lv;

    // Directed words: command sync, gap path, contiguous pair, all-ones parity
    stim.push_back(mk(16'hA5A5, 8'h01, 0, -1));
    stim.push_back(mk(16'h0001, 8'h00, WORD_CLKS + GAP_CLKS + 12, -1));
    stim.push_back(mk(16'hFFFF, 8'h00, 0, -1));
    stim.push_back(mk(16'h0000, 8'h01, 0, -1));
    stim.push_back(mk(16'hA5A5, 8'h03, WORD_CLKS + 20, -1));
    for (int i = 0; i < 20; i++) begin
      int sel;
      int dl;
      sel = int'($urandom_range(0, 3));
      if (sel < 2)       dl = 0;
      else if (sel == 2) dl = int'($urandom_range(1, WORD_CLKS + GAP_CLKS + 10));
      else               dl = WORD_CLKS + GAP_CLKS + int'($urandom_range(0, 30));
      stim.push_back(mk(16'($urandom), 8'($urandom), dl, -1));
    end
    stim.push_back(mk(16'h5A3C, 8'h01, 0, 99));
    stim.push_back(mk(16'hC003, 8'h00, 5, -1));
    stim.push_back(mk(16'($urandom), 8'($urandom), 0, -1));

    m_mode = 0; m_pos = 0; m_settle = 1'b1; m_abort = -1;
    have = 1'b0; dly = 0; rst_hold = 2; cycles = 0;
    cur = mk(16'h0, 8'h0, 0, -1);

    @(posedge aclk);
    @(negedge aclk);
    while (cycles < BUDGET &&
           !(stim.size() == 0 && !have && m_mode == 0 && !m_settle && rst_hold == 0)) begin
      // Expected outputs for the current clock
      exp_en   = (m_mode == 1);
      lv       = (m_mode == 1) ? m_lv[m_pos / HB] : 1'b0;
      exp_diff = (m_mode == 1) ? {lv, ~lv} : 2'b00;
      exp_rdy  = (m_mode == 0 && !m_settle) || (m_mode == 1 && m_pos == WORD_CLKS - 1);
      check_val("tready",  {31'd0, s_axis_tready}, {31'd0, exp_rdy});
      check_val("tx_en",   {31'd0, tx_en},         {31'd0, exp_en});
      check_val("tx_diff", {30'd0, tx_diff},       {30'd0, exp_diff});

      // Drive inputs for this clock
      if (rst_hold > 0) begin
        reset = 1'b1;
        rst_hold--;
      end else if (m_mode == 1 && m_pos == m_abort) begin
        reset    = 1'b1;
        rst_hold = 2;
      end else begin
        reset = 1'b0;
      end

      if (reset) begin
        s_axis_tvalid = 1'b0;
      end else begin
        if (!have && stim.size() > 0) begin
          cur  = stim.pop_front();
          have = 1'b1;
          dly  = cur.delay;
        end
        if (have && dly == 0) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = cur.data;
          s_axis_tuser  = cur.user;
        end else begin
          s_axis_tvalid = 1'b0;
          s_axis_tdata  = 16'($urandom);
          s_axis_tuser  = 8'($urandom);
          if (have) dly--;
        end
      end

      hs = !reset && s_axis_tvalid && exp_rdy;

      // Advance the model to the next clock
      if (reset) begin
        m_mode = 0; m_pos = 0; m_settle = 1'b1; m_abort = -1;
      end else begin
        case (m_mode)
          0: begin
            if (m_settle) m_settle = 1'b0;
            else if (hs) begin
              build_levels(cur.data, cur.user);
              m_mode = 1; m_pos = 0; m_abort = cur.abort_at;
            end
          end
          1: begin
            if (m_pos == WORD_CLKS - 1) begin
              if (hs) begin
                build_levels(cur.data, cur.user);
                m_pos = 0; m_abort = cur.abort_at;
              end else if (GAP_CLKS > 0) begin
                m_mode = 2; m_pos = 0;
              end else begin
                m_mode = 0;
              end
            end else begin
              m_pos++;
            end
          end
          default: begin
            if (m_pos == GAP_CLKS - 1) begin
              m_mode = 0; m_pos = 0;
            end else begin
              m_pos++;
            end
          end
        endcase
      end
      if (hs) have = 1'b0;

      @(negedge aclk);
      cycles++;
    end

    if (cycles >= BUDGET) check_val("timeout", 32'd1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
